// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared pipeline definitions: control-word packing, NOP encoding, opcodes and
// the ID-stage control decoder used to build id_ctrl.
package id_ex_hazard_reg_pkg;

  localparam int unsigned CTRL_W = 11;

  // Bit positions inside the packed control word.
  localparam int unsigned CTL_REGDST   = 10;
  localparam int unsigned CTL_ALUSRC   = 9;
  localparam int unsigned CTL_MEMTOREG = 8;
  localparam int unsigned CTL_REGWRITE = 7;
  localparam int unsigned CTL_MEMREAD  = 6;
  localparam int unsigned CTL_MEMWRITE = 5;
  localparam int unsigned CTL_BRANCH   = 4;
  localparam int unsigned CTL_ALUOP_HI = 3;
  localparam int unsigned CTL_ALUOP_LO = 2;
  localparam int unsigned CTL_JUMP     = 1;
  localparam int unsigned CTL_PAD      = 0;

  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  function automatic logic ctrl_memread(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTL_MEMREAD];
  endfunction

  function automatic logic ctrl_is_nop(input logic [CTRL_W-1:0] ctrl);
    return !(ctrl[CTL_REGWRITE] || ctrl[CTL_MEMREAD] || ctrl[CTL_MEMWRITE] ||
             ctrl[CTL_BRANCH] || ctrl[CTL_JUMP]);
  endfunction

  // Main decoder of the ID stage; unknown opcodes decode to a NOP.
  function automatic logic [CTRL_W-1:0] ctrl_decode(input logic [5:0] opcode);
    logic [CTRL_W-1:0] c;
    c = NOP_CTRL;
    case (opcode)
      OP_RTYPE: begin
        c[CTL_REGDST]   = 1'b1;
        c[CTL_REGWRITE] = 1'b1;
        c[CTL_ALUOP_HI] = 1'b1;
      end
      OP_LW: begin
        c[CTL_ALUSRC]   = 1'b1;
        c[CTL_MEMTOREG] = 1'b1;
        c[CTL_REGWRITE] = 1'b1;
        c[CTL_MEMREAD]  = 1'b1;
      end
      OP_SW: begin
        c[CTL_ALUSRC]   = 1'b1;
        c[CTL_MEMWRITE] = 1'b1;
      end
      OP_ADDI: begin
        c[CTL_ALUSRC]   = 1'b1;
        c[CTL_REGWRITE] = 1'b1;
      end
      OP_BEQ: begin
        c[CTL_BRANCH]   = 1'b1;
        c[CTL_ALUOP_LO] = 1'b1;
      end
      OP_J: c[CTL_JUMP] = 1'b1;
      default: c = NOP_CTRL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID -> EX bundle: decoded instruction in, registered instruction and stall
// controls out. The master side is the ID stage, the slave side the register.
interface id_ex_hazard_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  import id_ex_hazard_reg_pkg::*;

  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              flush;

  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              pc_write;
  logic              ifid_write;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_ctrl, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush,
    input  ex_ctrl, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
    input  pc_write, ifid_write, bubble_cnt
  );

  modport slave (
    input  id_ctrl, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush,
    output ex_ctrl, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
    output pc_write, ifid_write, bubble_cnt
  );

endinterface

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// Combinational load-use hazard detector; flush overrides the stall so the
// branch target is still fetched.
module id_ex_hazard_reg_hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              flush,
  output logic              hz,
  output logic              pc_write,
  output logic              ifid_write
);

  logic stall;

  // rt is compared even for I-type/J consumers; the odd spurious stall is accepted.
  always_comb begin
    hz         = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    stall      = hz && !flush;
    pc_write   = !stall;
    ifid_write = !stall;
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble injection, flush squash and a
// saturating bubble counter for performance debug.
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  id_ex_hazard_reg_if.slave bus
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pc4_q, rd1_q, rd2_q, imm_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hz;
  logic              bubble;

  id_ex_hazard_reg_hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_memread (ctrl_memread(ctrl_q)),
    .ex_rt      (rt_q),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .flush      (bus.flush),
    .hz         (hz),
    .pc_write   (bus.pc_write),
    .ifid_write (bus.ifid_write)
  );

  // Flush and stall both squash control; when they coincide only one bubble counts.
  always_comb begin
    bubble = bus.flush || hz;
    ctrl_d = bubble ? NOP_CTRL : bus.id_ctrl;
    cnt_d  = cnt_q;
    if (bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= NOP_CTRL;
      pc4_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pc4_q  <= bus.id_pc4;
      rd1_q  <= bus.id_rd1;
      rd2_q  <= bus.id_rd2;
      imm_q  <= bus.id_imm;
      rs_q   <= bus.id_rs;
      rt_q   <= bus.id_rt;
      rd_q   <= bus.id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    bus.ex_ctrl    = ctrl_q;
    bus.ex_pc4     = pc4_q;
    bus.ex_rd1     = rd1_q;
    bus.ex_rd2     = rd2_q;
    bus.ex_imm     = imm_q;
    bus.ex_rs      = rs_q;
    bus.ex_rt      = rt_q;
    bus.ex_rd      = rd_q;
    bus.bubble_cnt = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Table-driven bench for id_ex_hazard_reg with a scoreboard queue, plus corner
// sequences for asynchronous reset and counter saturation.
module tb_id_ex_hazard_reg;

  localparam logic [10:0] C_NOP = 11'h000;
  localparam logic [10:0] C_ADD = 11'h488;  // RegDst, RegWrite, ALUOp=10
  localparam logic [10:0] C_LW  = 11'h3C0;  // ALUSrc, MemtoReg, RegWrite, MemRead
  localparam logic [10:0] C_BEQ = 11'h014;  // Branch, ALUOp=01

  logic clk;
  logic reset;

  id_ex_hazard_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) m_bus ();
  id_ex_hazard_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  s_bus ();

  id_ex_hazard_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m_bus)
  );

  id_ex_hazard_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] ctrl;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        flush;
    logic        exp_pw;
    logic [10:0] exp_ctrl;
    logic [15:0] exp_cnt;
    bit          chk_data;
  } vec_t;

  typedef struct {
    logic [10:0] ctrl;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [15:0] cnt;
    bit          chk_data;
  } exp_t;

  vec_t tbl[15];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [10:0] ctrl, input logic [31:0] pc4,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic flush,
                              input logic exp_pw, input logic [10:0] exp_ctrl,
                              input logic [15:0] exp_cnt, input bit chk_data);
    vec_t v;
    v.ctrl = ctrl; v.pc4 = pc4; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
    v.rs = rs; v.rt = rt; v.rd = rd; v.flush = flush;
    v.exp_pw = exp_pw; v.exp_ctrl = exp_ctrl; v.exp_cnt = exp_cnt; v.chk_data = chk_data;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    m_bus.id_ctrl = v.ctrl;
    m_bus.id_pc4  = v.pc4;
    m_bus.id_rd1  = v.rd1;
    m_bus.id_rd2  = v.rd2;
    m_bus.id_imm  = v.imm;
    m_bus.id_rs   = v.rs;
    m_bus.id_rt   = v.rt;
    m_bus.id_rd   = v.rd;
    m_bus.flush   = v.flush;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("pc_write[%0d]", idx), {31'd0, m_bus.pc_write}, {31'd0, v.exp_pw});
    chk($sformatf("ifid_write[%0d]", idx), {31'd0, m_bus.ifid_write}, {31'd0, v.exp_pw});
    // Before the edge the register must still hold the previous instruction.
    if (idx == 0) chk("ex_ctrl_pre0", {21'd0, m_bus.ex_ctrl}, {21'd0, C_NOP});
    e.ctrl = v.exp_ctrl; e.pc4 = v.pc4; e.rd1 = v.rd1; e.rd2 = v.rd2; e.imm = v.imm;
    e.rs = v.rs; e.rt = v.rt; e.rd = v.rd; e.cnt = v.exp_cnt; e.chk_data = v.chk_data;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    chk($sformatf("ex_ctrl[%0d]", idx), {21'd0, m_bus.ex_ctrl}, {21'd0, got.ctrl});
    chk($sformatf("bubble_cnt[%0d]", idx), {16'd0, m_bus.bubble_cnt}, {16'd0, got.cnt});
    if (got.chk_data) begin
      chk($sformatf("ex_pc4[%0d]", idx), m_bus.ex_pc4, got.pc4);
      chk($sformatf("ex_rd1[%0d]", idx), m_bus.ex_rd1, got.rd1);
      chk($sformatf("ex_rd2[%0d]", idx), m_bus.ex_rd2, got.rd2);
      chk($sformatf("ex_imm[%0d]", idx), m_bus.ex_imm, got.imm);
      chk($sformatf("ex_regs[%0d]", idx), {17'd0, m_bus.ex_rs, m_bus.ex_rt, m_bus.ex_rd},
          {17'd0, got.rs, got.rt, got.rd});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   exp_sat;

    //        ctrl   pc4    rd1    rd2    imm    rs  rt  rd  fl pw exp_ctrl cnt chk
    tbl[0]  = mk(C_ADD, 32'h4,  32'h5,   32'h7,  32'h0,  1,  2,  3,  0, 1, C_ADD, 0, 1);
    tbl[1]  = mk(C_LW,  32'h8,  32'h100, 32'h0,  32'h10, 9,  8,  0,  0, 1, C_LW,  0, 1);
    tbl[2]  = mk(C_ADD, 32'hc,  32'h11,  32'h22, 32'h0,  8,  4,  10, 0, 0, C_NOP, 1, 0);
    tbl[3]  = mk(C_ADD, 32'hc,  32'h11,  32'h22, 32'h0,  8,  4,  10, 0, 1, C_ADD, 1, 1);
    tbl[4]  = mk(C_LW,  32'h10, 32'h200, 32'h0,  32'h4,  9,  0,  0,  0, 1, C_LW,  1, 1);
    tbl[5]  = mk(C_ADD, 32'h14, 32'h1,   32'h2,  32'h0,  0,  0,  11, 0, 1, C_ADD, 1, 1);
    tbl[6]  = mk(C_LW,  32'h18, 32'h300, 32'h0,  32'h8,  1,  9,  0,  0, 1, C_LW,  1, 1);
    tbl[7]  = mk(C_LW,  32'h1c, 32'h400, 32'h0,  32'hc,  9,  10, 0,  0, 0, C_NOP, 2, 0);
    tbl[8]  = mk(C_LW,  32'h1c, 32'h400, 32'h0,  32'hc,  9,  10, 0,  0, 1, C_LW,  2, 1);
    tbl[9]  = mk(C_ADD, 32'h20, 32'h33,  32'h44, 32'h0,  3,  10, 12, 0, 0, C_NOP, 3, 0);
    tbl[10] = mk(C_ADD, 32'h20, 32'h33,  32'h44, 32'h0,  3,  10, 12, 0, 1, C_ADD, 3, 1);
    tbl[11] = mk(C_LW,  32'h24, 32'h500, 32'h0,  32'h0,  1,  5,  0,  0, 1, C_LW,  3, 1);
    tbl[12] = mk(C_ADD, 32'h28, 32'h55,  32'h66, 32'h0,  5,  6,  13, 1, 1, C_NOP, 4, 0);
    tbl[13] = mk(C_BEQ, 32'h2c, 32'h77,  32'h88, 32'h3,  5,  6,  0,  1, 1, C_NOP, 5, 0);
    tbl[14] = mk(C_ADD, 32'h30, 32'h99,  32'haa, 32'h0,  5,  6,  14, 0, 1, C_ADD, 5, 1);

    reset = 1'b1;
    v = mk(C_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NOP, 0, 0);
    drive(v);
    s_bus.id_ctrl = C_NOP; s_bus.id_pc4 = '0; s_bus.id_rd1 = '0; s_bus.id_rd2 = '0;
    s_bus.id_imm = '0; s_bus.id_rs = '0; s_bus.id_rt = '0; s_bus.id_rd = '0;
    s_bus.flush = 1'b0;

    // Reset is asserted before any clock edge: outputs must already be clear.
    #2;
    chk("rst_ex_ctrl", {21'd0, m_bus.ex_ctrl}, 32'd0);
    chk("rst_ex_data", m_bus.ex_pc4 | m_bus.ex_rd1 | m_bus.ex_rd2 | m_bus.ex_imm, 32'd0);
    chk("rst_bubble_cnt", {16'd0, m_bus.bubble_cnt}, 32'd0);
    chk("rst_pc_write", {31'd0, m_bus.pc_write}, 32'd1);
    chk("rst_sat_cnt", {28'd0, s_bus.bubble_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) apply(tbl[i], i);

    // Reset landing mid-stall releases pc_write without a clock edge.
    v = mk(C_LW, 32'h34, 32'h600, 32'h0, 32'h0, 1, 7, 0, 0, 1, C_LW, 5, 1);
    apply(v, 15);
    @(negedge clk);
    v = mk(C_ADD, 32'h38, 32'h1, 32'h2, 32'h0, 7, 2, 15, 0, 0, C_NOP, 0, 0);
    drive(v);
    #1;
    chk("mid_stall_pc_write", {31'd0, m_bus.pc_write}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ex_ctrl", {21'd0, m_bus.ex_ctrl}, 32'd0);
    chk("mid_rst_ex_data", m_bus.ex_pc4 | m_bus.ex_rd1 | m_bus.ex_imm, 32'd0);
    chk("mid_rst_ex_rt", {27'd0, m_bus.ex_rt}, 32'd0);
    chk("mid_rst_bubble_cnt", {16'd0, m_bus.bubble_cnt}, 32'd0);
    chk("mid_rst_pc_write", {31'd0, m_bus.pc_write}, 32'd1);
    chk("mid_rst_ifid_write", {31'd0, m_bus.ifid_write}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // 4-bit counter: 20 flushes saturate at 15 and stay there.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_bus.flush = 1'b1;
      @(posedge clk);
      #1;
      exp_sat = (i + 1 > 15) ? 15 : i + 1;
      chk($sformatf("sat_cnt[%0d]", i), {28'd0, s_bus.bubble_cnt}, exp_sat);
    end
    @(negedge clk);
    s_bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", {28'd0, s_bus.bubble_cnt}, 32'd15);
    chk("sat_ex_ctrl", {21'd0, s_bus.ex_ctrl}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
